// File: rtl/video_vga_double_p_if.sv
// Signal bundle between the TV-rate colour pipeline and the VGA scandoubler.
//
// Handshake: pix_in_stb is a one-cycle valid that qualifies pix_in. There is
// no ready: the doubler accepts every strobe while its capture window is
// open, and a strobe that finds the current bank full is dropped and
// recorded in the sticky ovf flag.
//
// Signals (direction seen from the slave, i.e. the doubler):
//   hsync_start   in   one-clk pulse at TV line start (bank swap)
//   scanin_start  in   one-clk pulse opening the capture window
//   pix_in_stb    in   qualifies pix_in
//   pix_in        in   palette-applied colour, CH_W*NCH bits
//   scanline_en   in   dim the second replay of each line
//   pix_out       out  doubled colour, registered
//   vga_hsync     out  VGA hsync, active-high
//   vga_half      out  0 = first replay, 1 = second replay
//   ovf           out  sticky capture overflow
interface video_vga_double_p_if #(
   parameter int CH_W = 2,
   parameter int NCH  = 3
);
   logic                hsync_start;
   logic                scanin_start;
   logic                pix_in_stb;
   logic [CH_W*NCH-1:0] pix_in;
   logic                scanline_en;
   logic [CH_W*NCH-1:0] pix_out;
   logic                vga_hsync;
   logic                vga_half;
   logic                ovf;

   modport master (
      output hsync_start, scanin_start, pix_in_stb, pix_in, scanline_en,
      input  pix_out, vga_hsync, vga_half, ovf
   );

   modport slave (
      input  hsync_start, scanin_start, pix_in_stb, pix_in, scanline_en,
      output pix_out, vga_hsync, vga_half, ovf
   );
endinterface

// File: rtl/video_vga_double_p.sv
// Scandoubler with integrated VGA horizontal timing.
//
// One TV line of colour is captured into one bank of a ping-pong line
// buffer while the other bank (the previous line) is replayed twice at VGA
// rate. Each replay is one VGA line of HALF_LEN clocks with its own hsync.
// The second replay may be dimmed (each channel shifted right by one).
//
// Ports:
//   clk  28 MHz clock
//   rst  asynchronous reset, active-high
//   bus  video_vga_double_p_if.slave (capture inputs, VGA outputs, ovf)
module video_vga_double_p #(
   parameter int CH_W        = 2,
   parameter int NCH         = 3,
   parameter int ADDR_W      = 10,
   parameter int LINE_MAX    = 896,
   parameter int HALF_LEN    = 896,
   parameter int HSYNC_LEN   = 52,
   parameter int SCANOUT_OFS = 96,
   parameter int RD_LEN      = 720
) (
   input logic                    clk,
   input logic                    rst,
   video_vga_double_p_if.slave    bus
);
   localparam int PIX_W  = CH_W * NCH;
   localparam int HCNT_W = $clog2(HALF_LEN);
   // One extra bit so the write pointer can hold LINE_MAX itself.
   localparam int PTR_W  = ADDR_W + 1;

   localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(HALF_LEN - 1);
   localparam logic [HCNT_W-1:0] HSYNC_END = HCNT_W'(HSYNC_LEN);
   localparam logic [HCNT_W-1:0] WIN_LO    = HCNT_W'(SCANOUT_OFS);
   localparam logic [HCNT_W-1:0] WIN_HI    = HCNT_W'(SCANOUT_OFS + RD_LEN);
   localparam logic [PTR_W-1:0]  PTR_FULL  = PTR_W'(LINE_MAX);

   logic              wr_bank_q,   wr_bank_d;
   logic [PTR_W-1:0]  wr_ptr_q,    wr_ptr_d;
   logic              wr_active_q, wr_active_d;
   logic [PTR_W-1:0]  rd_cnt_q,    rd_cnt_d;
   logic [HCNT_W-1:0] hcnt_q,      hcnt_d;
   logic              vga_half_q,  vga_half_d;
   logic              vga_hsync_q, vga_hsync_d;
   logic              ovf_q,       ovf_d;
   logic              rd_valid_q,  rd_valid_d;
   logic              dim_q,       dim_d;
   logic [PIX_W-1:0]  pix_out_q,   pix_out_d;

   logic              wr_en;
   logic              rd_bank;
   logic              in_win;
   logic [HCNT_W-1:0] rd_ptr;
   logic [ADDR_W-1:0] rd_addr;
   logic [PIX_W-1:0]  dimmed;

   logic [PIX_W-1:0]  mem [2][LINE_MAX];
   logic [PIX_W-1:0]  ram_rd_q;

   // The read bank is always the one not being written.
   assign rd_bank = ~wr_bank_q;

   always_comb begin
      wr_bank_d   = wr_bank_q;
      wr_ptr_d    = wr_ptr_q;
      wr_active_d = wr_active_q;
      rd_cnt_d    = rd_cnt_q;
      hcnt_d      = hcnt_q;
      vga_half_d  = vga_half_q;
      ovf_d       = ovf_q;

      // Strobes in the swap cycle are ignored: the pointer is being reset.
      wr_en = !bus.hsync_start && wr_active_q && bus.pix_in_stb &&
              (wr_ptr_q < PTR_FULL);

      if (bus.hsync_start) begin
         wr_bank_d   = ~wr_bank_q;
         rd_cnt_d    = wr_ptr_q;
         wr_ptr_d    = '0;
         wr_active_d = 1'b0;
         hcnt_d      = '0;
         vga_half_d  = 1'b0;
      end else begin
         if (hcnt_q == HCNT_LAST) begin
            hcnt_d     = '0;
            vga_half_d = ~vga_half_q;
         end else begin
            hcnt_d = hcnt_q + HCNT_W'(1);
         end
         if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (wr_active_q && bus.pix_in_stb && (wr_ptr_q == PTR_FULL)) begin
            ovf_d = 1'b1;
         end
      end

      // Applied after the swap so a coincident scanin_start opens the new line.
      if (bus.scanin_start) begin
         wr_active_d = 1'b1;
      end

      // hsync is registered from the next count so it lines up with hcnt_q.
      vga_hsync_d = (hcnt_d < HSYNC_END);

      // Read stage: address and qualifiers for this cycle's RAM read.
      in_win     = (hcnt_q >= WIN_LO) && (hcnt_q < WIN_HI);
      rd_ptr     = hcnt_q - WIN_LO;
      rd_valid_d = in_win && (PTR_W'(rd_ptr) < rd_cnt_q);
      rd_addr    = rd_valid_d ? ADDR_W'(rd_ptr) : '0;
      dim_d      = bus.scanline_en && vga_half_q;

      // Output stage: each channel halved independently for scanlines.
      dimmed = ram_rd_q;
      for (int ch = 0; ch < NCH; ch++) begin
         dimmed[ch*CH_W +: CH_W] = ram_rd_q[ch*CH_W +: CH_W] >> 1;
      end
      if (!rd_valid_q) begin
         pix_out_d = '0;
      end else if (dim_q) begin
         pix_out_d = dimmed;
      end else begin
         pix_out_d = ram_rd_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_bank_q   <= 1'b0;
         wr_ptr_q    <= '0;
         wr_active_q <= 1'b0;
         rd_cnt_q    <= '0;
         hcnt_q      <= '0;
         vga_half_q  <= 1'b0;
         vga_hsync_q <= 1'b0;
         ovf_q       <= 1'b0;
         rd_valid_q  <= 1'b0;
         dim_q       <= 1'b0;
         pix_out_q   <= '0;
      end else begin
         wr_bank_q   <= wr_bank_d;
         wr_ptr_q    <= wr_ptr_d;
         wr_active_q <= wr_active_d;
         rd_cnt_q    <= rd_cnt_d;
         hcnt_q      <= hcnt_d;
         vga_half_q  <= vga_half_d;
         vga_hsync_q <= vga_hsync_d;
         ovf_q       <= ovf_d;
         rd_valid_q  <= rd_valid_d;
         dim_q       <= dim_d;
         pix_out_q   <= pix_out_d;
      end
   end

   // Line buffer: one write and one synchronous read per cycle. The two
   // ports always address different banks, so there is no collision.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_bank_q][wr_ptr_q[ADDR_W-1:0]] <= bus.pix_in;
      end
      ram_rd_q <= mem[rd_bank][rd_addr];
   end

   assign bus.pix_out   = pix_out_q;
   assign bus.vga_hsync = vga_hsync_q;
   assign bus.vga_half  = vga_half_q;
   assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_video_vga_double_p.sv
// Self-checking bench for video_vga_double_p. Each TV line is driven by
// run_tv_line, which records every output per cycle; the scenario tasks
// compare those records against a behavioural model of the line replay.
module tb_video_vga_double_p;
   localparam int CH_W        = 2;
   localparam int NCH         = 3;
   localparam int PIX_W       = CH_W * NCH;
   localparam int ADDR_W      = 10;
   localparam int LINE_MAX    = 896;
   localparam int HALF_LEN    = 896;
   localparam int HSYNC_LEN   = 52;
   localparam int SCANOUT_OFS = 96;
   localparam int RD_LEN      = 720;
   localparam int TV_LEN      = 2 * HALF_LEN + 1;

   logic clk = 1'b0;
   logic rst;

   always #18 clk = ~clk;

   video_vga_double_p_if #(.CH_W(CH_W), .NCH(NCH)) bus ();

   video_vga_double_p #(
      .CH_W(CH_W), .NCH(NCH), .ADDR_W(ADDR_W), .LINE_MAX(LINE_MAX),
      .HALF_LEN(HALF_LEN), .HSYNC_LEN(HSYNC_LEN),
      .SCANOUT_OFS(SCANOUT_OFS), .RD_LEN(RD_LEN)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Model: line being captured, line being replayed, and the one before.
   logic [PIX_W-1:0] cap       [LINE_MAX];
   logic [PIX_W-1:0] play      [LINE_MAX];
   logic [PIX_W-1:0] prev_play [LINE_MAX];
   int               cap_cnt  = 0;
   int               play_cnt = 0;
   bit               cur_scan = 1'b0;
   int               cur_len  = 0;

   // Per-cycle record of the current TV line; index 0 is the hsync_start cycle.
   logic [PIX_W-1:0] obs_pix  [TV_LEN];
   logic             obs_hs   [TV_LEN];
   logic             obs_half [TV_LEN];
   logic             obs_ovf  [TV_LEN];

   // Halve every channel of a pixel.
   function automatic logic [PIX_W-1:0] dim_model(input logic [PIX_W-1:0] p);
      int v;
      int res;
      res = 0;
      for (int ch = 0; ch < NCH; ch++) begin
         v   = (int'(p) >> (ch * CH_W)) % (1 << CH_W);
         res = res + ((v / 2) << (ch * CH_W));
      end
      return PIX_W'(res);
   endfunction

   // Expected pix_out n cycles after the first hcnt==0 cycle of a line.
   function automatic logic [PIX_W-1:0] exp_pix(input int n);
      int r;
      int k;
      bit second;
      r = n - 2;
      if (r < 0) return '0;
      second = ((r / HALF_LEN) % 2) == 1;
      k = (r % HALF_LEN) - SCANOUT_OFS;
      if (k < 0 || k >= RD_LEN || k >= play_cnt) return '0;
      return (cur_scan && second) ? dim_model(play[k]) : play[k];
   endfunction

   // Expected {vga_hsync, vga_half} n cycles after the line start.
   function automatic logic [1:0] exp_timing(input int n);
      return {((n % HALF_LEN) < HSYNC_LEN), (((n / HALF_LEN) % 2) == 1)};
   endfunction

   // One TV line: hsync_start+scanin_start in cycle 0, nstb strobes in
   // cycles 1..nstb (nstb < len-1), next line starts len cycles later.
   task automatic run_tv_line(input int nstb, input bit count_pat,
                              input bit scan, input int len);
      logic [PIX_W-1:0] p;
      prev_play = play;
      play      = cap;
      play_cnt  = cap_cnt;
      cap_cnt   = 0;
      cur_scan  = scan;
      cur_len   = len;
      for (int c = 0; c < len; c++) begin
         @(posedge clk);
         #1;
         obs_pix[c]  = bus.pix_out;
         obs_hs[c]   = bus.vga_hsync;
         obs_half[c] = bus.vga_half;
         obs_ovf[c]  = bus.ovf;
         bus.hsync_start  = (c == 0);
         bus.scanin_start = (c == 0);
         bus.scanline_en  = scan;
         if (c >= 1 && c <= nstb) begin
            p = count_pat ? PIX_W'(c - 1) : PIX_W'($urandom_range(0, (1 << PIX_W) - 1));
            bus.pix_in_stb = 1'b1;
            bus.pix_in     = p;
            if (cap_cnt < LINE_MAX) begin
               cap[cap_cnt] = p;
               cap_cnt++;
            end
         end else begin
            bus.pix_in_stb = 1'b0;
            bus.pix_in     = PIX_W'($urandom);
         end
      end
   endtask

   task automatic test_reset();
      run_tv_line(720, 1'b0, 1'b0, TV_LEN);
      run_tv_line(300, 1'b0, 1'b0, 1000);
      @(posedge clk);
      #10;
      rst = 1'b1;
      #1;
      n_chk++;
      if ({bus.pix_out, bus.vga_hsync, bus.vga_half, bus.ovf} !== '0) begin
         n_fail++;
         $display("FAIL reset_immediate got %b required 0",
                  {bus.pix_out, bus.vga_hsync, bus.vga_half, bus.ovf});
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         n_chk++;
         if ({bus.pix_out, bus.vga_hsync, bus.vga_half, bus.ovf} !== '0) begin
            n_fail++;
            $display("FAIL reset_hold cycle=%0d got %b required 0", i,
                     {bus.pix_out, bus.vga_hsync, bus.vga_half, bus.ovf});
         end
      end
      rst = 1'b0;
      cap_cnt = 0;
      run_tv_line(0, 1'b0, 1'b0, TV_LEN);
      for (int c = 1; c < cur_len; c++) begin
         n_chk++;
         if (obs_pix[c] !== '0) begin
            n_fail++;
            $display("FAIL reset_empty_pix c=%0d got %h required 0", c, obs_pix[c]);
         end
         n_chk++;
         if ({obs_hs[c], obs_half[c]} !== exp_timing(c - 1)) begin
            n_fail++;
            $display("FAIL reset_timing c=%0d got %b required %b", c,
                     {obs_hs[c], obs_half[c]}, exp_timing(c - 1));
         end
      end
   endtask

   task automatic test_line_a();
      int hs_cnt [2];
      run_tv_line(720, 1'b1, 1'b0, TV_LEN);
      // Replay of line A while capturing the same ramp for the next test.
      run_tv_line(720, 1'b1, 1'b0, TV_LEN);
      hs_cnt[0] = 0;
      hs_cnt[1] = 0;
      for (int c = 1; c < cur_len; c++) begin
         if (obs_hs[c] === 1'b1) hs_cnt[(c - 1) / HALF_LEN]++;
         n_chk++;
         if ({obs_hs[c], obs_half[c]} !== exp_timing(c - 1)) begin
            n_fail++;
            $display("FAIL line_a_timing c=%0d got %b required %b", c,
                     {obs_hs[c], obs_half[c]}, exp_timing(c - 1));
         end
         n_chk++;
         if (obs_pix[c] !== exp_pix(c - 1)) begin
            n_fail++;
            $display("FAIL line_a_pix c=%0d got %h required %h", c, obs_pix[c], exp_pix(c - 1));
         end
      end
      for (int h = 0; h < 2; h++) begin
         n_chk++;
         if (hs_cnt[h] != HSYNC_LEN) begin
            n_fail++;
            $display("FAIL line_a_hsync_len half=%0d got %0d required %0d", h, hs_cnt[h], HSYNC_LEN);
         end
      end
      n_chk++;
      if (obs_pix[99 + 64] !== 6'h00 || obs_pix[99 + 63] !== 6'h3f) begin
         n_fail++;
         $display("FAIL line_a_wrap got %h,%h required 3f,00", obs_pix[162], obs_pix[163]);
      end
   endtask

   task automatic test_scanline();
      run_tv_line(100, 1'b0, 1'b1, TV_LEN);
      for (int c = 3; c < cur_len; c++) begin
         n_chk++;
         if (obs_pix[c] !== exp_pix(c - 1)) begin
            n_fail++;
            $display("FAIL scanline_pix c=%0d got %h required %h", c, obs_pix[c], exp_pix(c - 1));
         end
      end
      n_chk++;
      if (obs_pix[99 + 63] !== 6'h3f) begin
         n_fail++;
         $display("FAIL scanline_first got %h required 3f", obs_pix[99 + 63]);
      end
      n_chk++;
      if (obs_pix[99 + 63 + HALF_LEN] !== 6'h15) begin
         n_fail++;
         $display("FAIL scanline_second got %h required 15", obs_pix[99 + 63 + HALF_LEN]);
      end
   endtask

   task automatic test_short_line();
      // Previous run already captured exactly 100 random pixels.
      run_tv_line(0, 1'b0, 1'b0, TV_LEN);
      for (int c = 3; c < cur_len; c++) begin
         n_chk++;
         if (obs_pix[c] !== exp_pix(c - 1)) begin
            n_fail++;
            $display("FAIL short_pix c=%0d got %h required %h", c, obs_pix[c], exp_pix(c - 1));
         end
      end
      for (int h = 0; h < 2; h++) begin
         n_chk++;
         if (obs_pix[99 + 100 + h * HALF_LEN] !== '0) begin
            n_fail++;
            $display("FAIL short_tail half=%0d got %h required 0", h, obs_pix[99 + 100 + h * HALF_LEN]);
         end
      end
   endtask

   task automatic test_overflow();
      run_tv_line(900, 1'b1, 1'b0, TV_LEN);
      for (int c = 1; c < cur_len; c++) begin
         n_chk++;
         if (obs_ovf[c] !== (c >= 898)) begin
            n_fail++;
            $display("FAIL ovf_rise c=%0d got %b required %b", c, obs_ovf[c], (c >= 898));
         end
      end
      for (int line = 0; line < 2; line++) begin
         run_tv_line(40, 1'b0, 1'b0, TV_LEN);
         for (int c = 1; c < cur_len; c++) begin
            n_chk++;
            if (obs_ovf[c] !== 1'b1) begin
               n_fail++;
               $display("FAIL ovf_sticky line=%0d c=%0d got %b required 1", line, c, obs_ovf[c]);
            end
            if (line == 0 && c >= 3) begin
               n_chk++;
               if (obs_pix[c] !== exp_pix(c - 1)) begin
                  n_fail++;
                  $display("FAIL ovf_pix c=%0d got %h required %h", c, obs_pix[c], exp_pix(c - 1));
               end
            end
         end
      end
   endtask

   task automatic test_truncate();
      run_tv_line(720, 1'b0, 1'b0, TV_LEN);
      // hsync_start lands on hcnt==400 of the first half.
      run_tv_line(399, 1'b0, 1'b0, 401);
      for (int c = 1; c < cur_len; c++) begin
         n_chk++;
         if (obs_pix[c] !== exp_pix(c - 1) || {obs_hs[c], obs_half[c]} !== exp_timing(c - 1)) begin
            n_fail++;
            $display("FAIL trunc_pre c=%0d got %h/%b required %h/%b", c, obs_pix[c],
                     {obs_hs[c], obs_half[c]}, exp_pix(c - 1), exp_timing(c - 1));
         end
      end
      run_tv_line(0, 1'b0, 1'b0, TV_LEN);
      n_chk++;
      if ({obs_hs[1], obs_half[1]} !== 2'b10) begin
         n_fail++;
         $display("FAIL trunc_restart got %b required 10", {obs_hs[1], obs_half[1]});
      end
      n_chk++;
      if (obs_pix[1] !== prev_play[303] || obs_pix[2] !== prev_play[304]) begin
         n_fail++;
         $display("FAIL trunc_old_bank got %h,%h required %h,%h", obs_pix[1], obs_pix[2],
                  prev_play[303], prev_play[304]);
      end
      for (int c = 3; c < cur_len; c++) begin
         n_chk++;
         if (obs_pix[c] !== exp_pix(c - 1) || {obs_hs[c], obs_half[c]} !== exp_timing(c - 1)) begin
            n_fail++;
            $display("FAIL trunc_new c=%0d got %h/%b required %h/%b", c, obs_pix[c],
                     {obs_hs[c], obs_half[c]}, exp_pix(c - 1), exp_timing(c - 1));
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int line = 0; line < 4; line++) begin
         run_tv_line($urandom_range(0, LINE_MAX + 10), 1'b0, 1'($urandom_range(0, 1)), TV_LEN);
         for (int c = 3; c < cur_len; c++) begin
            n_chk++;
            if (obs_pix[c] !== exp_pix(c - 1) || {obs_hs[c], obs_half[c]} !== exp_timing(c - 1)) begin
               n_fail++;
               $display("FAIL b2b line=%0d c=%0d got %h/%b required %h/%b", line, c, obs_pix[c],
                        {obs_hs[c], obs_half[c]}, exp_pix(c - 1), exp_timing(c - 1));
            end
         end
      end
   endtask

   initial begin
      rst              = 1'b1;
      bus.hsync_start  = 1'b0;
      bus.scanin_start = 1'b0;
      bus.pix_in_stb   = 1'b0;
      bus.pix_in       = '0;
      bus.scanline_en  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      test_reset();
      test_line_a();
      test_scanline();
      test_short_line();
      test_overflow();
      test_truncate();
      test_back_to_back();
      test_reset();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/video_vga_double_p.md
Name: video_vga_double_p

Overview:
- Parametrised scandoubler with integrated VGA horizontal timing.
- Next-generation replacement for the fixed 6-bit doubler plus separate VGA hsync generator in the video pipeline.
- Captures one TV line of palette-applied colour into a ping-pong line buffer, then replays the previous line twice at VGA rate, with its own VGA hsync.
- Generalised over channel width, channel count and line depth. Adds:
  - valid-length tracking;
  - an overflow flag;
  - optional scanline dimming of the second replay.

Parameters:
CH_W, 2, bits per colour channel
NCH, 3, number of colour channels; pixel width PIX_W = CH_W*NCH
ADDR_W, 10, line buffer address width
LINE_MAX, 896, usable entries per buffer bank; must be <= 2**ADDR_W
HALF_LEN, 896, clk cycles per VGA line (half a TV line)
HSYNC_LEN, 52, VGA hsync pulse length in clk cycles
SCANOUT_OFS, 96, clk cycles from VGA line start to first output pixel
RD_LEN, 720, output pixels per VGA line

Ports:
clk  in  1  28 MHz clock
rst  in  1  asynchronous reset, active-high
hsync_start  in  1  one-clk pulse, TV line start
scanin_start  in  1  one-clk pulse, opens capture window for current TV line
pix_in_stb  in  1  qualifies pix_in (one pulse per TV pixel)
pix_in  in  PIX_W  input colour
scanline_en  in  1  dim second replay when 1
pix_out  out  PIX_W  doubled colour, registered
vga_hsync  out  1  VGA hsync, active-high (polarity handled in output mux)
vga_half  out  1  0 = first replay, 1 = second replay of current line
ovf  out  1  sticky: capture overflowed a bank since reset

Behaviour:
- Reset (async, rst=1) clears the following, effective immediately and held until rst falls:
  - pix_out=0, vga_hsync=0, vga_half=0, ovf=0;
  - wr_bank=0, wr_ptr=0, wr_active=0;
  - rd_cnt=0, hcnt=0.
- Buffer: 2 banks x LINE_MAX x PIX_W, synchronous-read RAM; one write port and one read port per cycle.
- On hsync_start:
  - wr_bank toggles; rd_bank becomes the old wr_bank;
  - rd_cnt latches the old wr_ptr (number of valid entries);
  - wr_ptr=0, wr_active=0;
  - hcnt=0, vga_half=0.
- scanin_start sets wr_active=1. If it coincides with hsync_start, the swap happens and wr_active=1 takes effect in the same cycle.
- Write: when wr_active && pix_in_stb && wr_ptr<LINE_MAX, write pix_in to [wr_bank][wr_ptr] and increment wr_ptr.
  - wr_ptr saturates at LINE_MAX; no wrap.
  - pix_in_stb while wr_active && wr_ptr==LINE_MAX sets ovf=1 and the pixel is dropped.
- VGA timing:
  - hcnt counts 0..HALF_LEN-1 and wraps to 0; vga_half toggles on each wrap.
  - Without a new hsync_start, replay continues from the same rd_bank (vga_half keeps toggling).
  - vga_hsync=1 when registered hcnt in [0, HSYNC_LEN-1].
  - hsync_start mid-line truncates the current VGA line; the next hsync pulse starts at hcnt=0.
- Read window: hcnt in [SCANOUT_OFS, SCANOUT_OFS+RD_LEN-1]. rd_ptr = hcnt - SCANOUT_OFS.
  - Latency: pix_out for rd_ptr=k appears 2 clks after the cycle hcnt==SCANOUT_OFS+k (RAM read + output register).
  - Window timing is identical for both halves.
- Output value:
  - outside the window, or rd_ptr >= rd_cnt: pix_out=0;
  - otherwise the stored pixel;
  - if scanline_en && vga_half==1: each CH_W channel logically shifted right by 1 (2'b11 becomes 2'b01).
  - scanline_en is sampled in the same cycle as the RAM read address.
- Simultaneous write and read of the same address cannot occur, because banks differ. If hsync_start coincides with a read, the read uses the new rd_bank from the next cycle.

Test Plan:
- Reset held for 5 clks mid-stream -> all outputs 0. After release, the first hsync_start gives rd_cnt=0, so pix_out stays 0 through both halves.
- Line A: scanin_start, then 720 strobes of pix_in=k[5:0]. Next hsync_start -> pix_out sequence 0,1,..,63,0,.. starting 2 clks after hcnt==96, repeated identically at vga_half=1. vga_hsync high exactly 52 clks at each VGA line start.
- Same line with scanline_en=1 -> first replay gives pix 6'b111111; second replay gives 6'b010101.
- Capture of only 100 pixels -> replay shows 100 pixels, then pix_out=0 for rd_ptr 100..719.
- 900 strobes in one line -> the first 896 are stored, ovf=1 from the 897th strobe, and ovf stays 1 after later lines until reset.
- hsync_start at hcnt=400 of the first half -> hsync restarts next cycle, vga_half=0, and the replay switches to the just-captured bank.
